// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared definitions for the single-outstanding AXI4 master:
//   - default address/data widths and watchdog limit
//   - FSM state encoding
//   - watchdog counter width helper ($clog2(TIMEOUT_CYCLES)+1)
// -----------------------------------------------------------------------------
package axi4_pkg;

  localparam int AXI4_ADDR_W         = 32;
  localparam int AXI4_DATA_W         = 32;
  localparam int AXI4_TIMEOUT_CYCLES = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } axi4_state_e;

  // One spare bit so the counter can hold TIMEOUT_CYCLES-1 for any limit.
  function automatic int axi4_ctr_width(input int timeout_cycles);
    return $clog2(timeout_cycles) + 1;
  endfunction

  localparam int AXI4_CTR_W = axi4_ctr_width(AXI4_TIMEOUT_CYCLES);

endpackage

// File: rtl/axi4_timeout_ctr.sv
// -----------------------------------------------------------------------------
// axi4_timeout_ctr
// Watchdog for the AXI4 master. Counts completed waiting cycles of the
// current transaction and flags when the limit is hit.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : restart the count (command accepted)
//   en           : master is waiting on the slave this cycle
//   expired      : abort the transaction on the coming edge
// -----------------------------------------------------------------------------
module axi4_timeout_ctr
  import axi4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = AXI4_TIMEOUT_CYCLES,
  parameter int CTR_W          = axi4_ctr_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count reaches TIMEOUT_CYCLES-1 on the edge after a cycle that sees
  // TIMEOUT_CYCLES-2, so the abort is taken on that same edge. Using >=
  // keeps the flag asserted if a partial handshake moved the FSM on to
  // another waiting state right at the limit.
  localparam logic [CTR_W-1:0] LAST_WAIT = CTR_W'(TIMEOUT_CYCLES - 2);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q >= LAST_WAIT);

endmodule

// File: rtl/axi4_master.sv
// -----------------------------------------------------------------------------
// axi4_master
// Single-outstanding AXI4 master (reduced channel set: no ID/LEN/STRB/RESP).
// Converts a command/response handshake into one AW/W/B write or AR/R read.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake; cmd_write selects direction,
//                            cmd_addr / cmd_wdata carry the request
//   rsp_valid              : one-cycle completion pulse with rsp_rdata/rsp_err
//   busy                   : high whenever the FSM is not idle
//   aw*/w*/b*/ar*/r*       : AXI4 master channels
// Build option:
//   AXI4_MASTER_TIMEOUT_EN : adds a watchdog that aborts a transaction after
//                            TIMEOUT_CYCLES with rsp_err=1. Without it the
//                            master waits indefinitely and rsp_err stays 0.
// All outputs are registered.
// -----------------------------------------------------------------------------
module axi4_master
  import axi4_pkg::*;
#(
  parameter int ADDR_W         = AXI4_ADDR_W,
  parameter int DATA_W         = AXI4_DATA_W,
  parameter int TIMEOUT_CYCLES = AXI4_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready
);

  axi4_state_e       state_q,     state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q,      busy_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              awvalid_q,   awvalid_d;
  logic              wvalid_q,    wvalid_d;
  logic              bready_q,    bready_d;
  logic              arvalid_q,   arvalid_d;
  logic              rready_q,    rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  logic cmd_fire;
  logic timeout_hit;
  logic abort;

  assign cmd_fire = cmd_valid && cmd_ready_q;

`ifdef AXI4_MASTER_TIMEOUT_EN
  logic wait_state;

  assign wait_state = (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_REQ)  || (state_q == ST_RD_DATA);

  axi4_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cmd_fire),
    .en      (wait_state),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = 1'b0;
    rready_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    abort       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          addr_d = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end

      ST_WR_REQ: begin
        // AW and W retire independently; leave once both valids have dropped.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      ST_WR_RESP: begin
        if (bvalid && bready_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_DONE;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          bready_d = 1'b1;
        end
      end

      ST_RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      ST_RD_DATA: begin
        if (rvalid && rready_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          state_d     = ST_DONE;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          rready_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog abort: withdraw everything and report an error completion.
    if (abort) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      state_d     = ST_DONE;
    end

    // Pulses with rsp_valid only; constant 0 when the watchdog is not built.
    rsp_err_d   = abort;
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_axi4_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_master
// Directed bench for axi4_master with a small memory-backed slave whose
// per-channel ready/valid delays are set by each test. Cycle numbers are
// counted from the command-acceptance cycle (cycle 0).
// -----------------------------------------------------------------------------
module tb_axi4_master;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  axi4_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // slave configuration
  int   aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic b_never;
  logic [31:0] mem [0:63];

  // per-cycle history of the last command
  logic        h_awv [0:63];
  logic        h_wv  [0:63];
  logic [31:0] h_wd  [0:63];
  logic        h_br  [0:63];
  logic        h_arv [0:63];
  logic        h_rr  [0:63];
  logic        h_rsp [0:63];
  logic        h_crdy[0:63];
  logic        h_busy[0:63];
  int          r_cycle, r_pulses, r_last, r_wait;
  logic [31:0] r_data;
  logic        r_err;

  // Slave: updates readies/valids each falling edge for the coming rising edge.
  initial begin : slave
    int aw_wait, w_wait, b_wait, ar_wait, rd_wait;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; rd_wait = 0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (awvalid) begin awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= w_delay); w_wait++; end
      else begin wready = 1'b0; w_wait = 0; end
      if (wvalid && wready) mem[awaddr[7:2]] = wdata;
      if (bready) begin bvalid = !b_never && (b_wait >= b_delay); b_wait++; end
      else begin bvalid = 1'b0; b_wait = 0; end
      if (arvalid) begin arready = (ar_wait >= ar_delay); ar_wait++; end
      else begin arready = 1'b0; ar_wait = 0; end
      if (rready) begin rvalid = (rd_wait >= r_delay); rd_wait++; end
      else begin rvalid = 1'b0; rd_wait = 0; end
      rdata = rvalid ? mem[araddr[7:2]] : 32'h0;
    end
  end

  task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  // Issue one command (called at a falling edge) and record up to the cycle
  // after the response, or maxc cycles if no response arrives.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int maxc);
    r_wait = 0;
    while (!cmd_ready && r_wait < 20) begin @(negedge clk); r_wait++; end
    for (int i = 0; i < 64; i++) begin
      h_awv[i] = 0; h_wv[i] = 0; h_wd[i] = 0; h_br[i] = 0; h_arv[i] = 0;
      h_rr[i] = 0; h_rsp[i] = 0; h_crdy[i] = 0; h_busy[i] = 0;
    end
    r_cycle = -1; r_pulses = 0; r_last = 0; r_data = 'x; r_err = 1'bx;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (k == 1) begin cmd_valid = 1'b0; cmd_wdata = '0; cmd_addr = '0; end
      h_awv[k] = awvalid; h_wv[k] = wvalid; h_wd[k] = wdata; h_br[k] = bready;
      h_arv[k] = arvalid; h_rr[k] = rready; h_rsp[k] = rsp_valid;
      h_crdy[k] = cmd_ready; h_busy[k] = busy;
      r_last = k;
      if (rsp_valid) begin
        r_pulses++;
        if (r_cycle < 0) begin r_cycle = k; r_data = rsp_rdata; r_err = rsp_err; end
      end
      if (r_cycle >= 0 && k == r_cycle + 1) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    b_never = 1'b0; set_slave(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
    n_cmp++; if ({busy, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err} !== 8'h00) begin
      n_bad++; $display("FAIL rst_ctrl_outs: got %b exp 00000000", {busy, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}); end
    n_cmp++; if ({awaddr, wdata, araddr, rsp_rdata} !== 128'h0) begin
      n_bad++; $display("FAIL rst_data_outs: got %h exp 0", {awaddr, wdata, araddr, rsp_rdata}); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_release_ready: got %b exp 0", cmd_ready); end
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_first_cycle_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait;
    set_slave(0, 0, 0, 0, 0);
    run_cmd(1'b1, 32'h10, 32'hDEADBEEF, 20);
    n_cmp++; if ({h_awv[1], h_wv[1], h_busy[1]} !== 3'b111) begin n_bad++; $display("FAIL wr0_valids_c1: got %b exp 111", {h_awv[1], h_wv[1], h_busy[1]}); end
    n_cmp++; if ({h_awv[2], h_wv[2], h_br[2]} !== 3'b001) begin n_bad++; $display("FAIL wr0_c2: got %b exp 001", {h_awv[2], h_wv[2], h_br[2]}); end
    n_cmp++; if (r_cycle !== 3) begin n_bad++; $display("FAIL wr0_rsp_cycle: got %0d exp 3", r_cycle); end
    n_cmp++; if ({r_err, r_data} !== 33'h0) begin n_bad++; $display("FAIL wr0_rsp: got err=%b data=%h exp err=0 data=0", r_err, r_data); end
    n_cmp++; if ({h_crdy[3], h_crdy[4], h_busy[4]} !== 3'b010) begin n_bad++; $display("FAIL wr0_ready_c3c4: got %b exp 010", {h_crdy[3], h_crdy[4], h_busy[4]}); end
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr0_mem: got %h exp deadbeef", mem[4]); end
  endtask

  task automatic test_read_back_to_back;
    set_slave(0, 0, 0, 0, 0);
    run_cmd(1'b0, 32'h10, 32'h0, 20);
    n_cmp++; if ({h_arv[1], h_arv[2], h_rr[2]} !== 3'b101) begin n_bad++; $display("FAIL rd0_chan: got %b exp 101", {h_arv[1], h_arv[2], h_rr[2]}); end
    n_cmp++; if (r_cycle !== 3) begin n_bad++; $display("FAIL rd0_rsp_cycle: got %0d exp 3", r_cycle); end
    n_cmp++; if (r_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd0_data: got %h exp deadbeef", r_data); end
    // second read issued at the first cycle cmd_ready returns (cycle 4)
    run_cmd(1'b0, 32'h10, 32'h0, 20);
    n_cmp++; if (r_wait !== 0) begin n_bad++; $display("FAIL b2b_accept_wait: got %0d exp 0", r_wait); end
    n_cmp++; if ({r_cycle, r_data} !== {32'd3, 32'hDEADBEEF}) begin n_bad++; $display("FAIL b2b_rsp: got c%0d %h exp c3 deadbeef", r_cycle, r_data); end
  endtask

  task automatic test_write_stalls;
    int awn, wn;
    logic stable;
    // W accepted 3 cycles after AW
    set_slave(0, 3, 0, 0, 0);
    run_cmd(1'b1, 32'h14, 32'hCAFEF00D, 30);
    awn = 0; wn = 0; stable = 1'b1;
    for (int k = 1; k <= r_last; k++) begin
      if (h_awv[k]) awn++;
      if (h_wv[k]) begin wn++; if (h_wd[k] !== 32'hCAFEF00D) stable = 1'b0; end
    end
    n_cmp++; if (awn !== 1) begin n_bad++; $display("FAIL wstall_aw_cycles: got %0d exp 1", awn); end
    n_cmp++; if (wn !== 4) begin n_bad++; $display("FAIL wstall_w_cycles: got %0d exp 4", wn); end
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL wstall_wdata_stable: got %b exp 1", stable); end
    n_cmp++; if ({r_cycle, r_pulses} !== {32'd6, 32'd1}) begin n_bad++; $display("FAIL wstall_rsp: got c%0d n%0d exp c6 n1", r_cycle, r_pulses); end
    // AW accepted 2 cycles after W
    set_slave(2, 0, 0, 0, 0);
    run_cmd(1'b1, 32'h18, 32'h0BADF00D, 30);
    awn = 0; wn = 0;
    for (int k = 1; k <= r_last; k++) begin
      if (h_awv[k]) awn++;
      if (h_wv[k]) wn++;
    end
    n_cmp++; if ({awn, wn} !== {32'd3, 32'd1}) begin n_bad++; $display("FAIL awstall_cycles: got aw%0d w%0d exp aw3 w1", awn, wn); end
    n_cmp++; if ({r_cycle, r_pulses, mem[6]} !== {32'd5, 32'd1, 32'h0BADF00D}) begin
      n_bad++; $display("FAIL awstall_rsp: got c%0d n%0d m%h exp c5 n1 m0badf00d", r_cycle, r_pulses, mem[6]); end
  endtask

  task automatic test_read_stall;
    int rn;
    set_slave(0, 0, 0, 0, 0);
    run_cmd(1'b1, 32'h20, 32'h12345678, 20);
    set_slave(0, 0, 0, 0, 5);
    run_cmd(1'b0, 32'h20, 32'h0, 30);
    rn = 0;
    for (int k = 2; k <= 7; k++) if (h_rr[k]) rn++;
    n_cmp++; if (rn !== 6) begin n_bad++; $display("FAIL rstall_rready_held: got %0d exp 6", rn); end
    n_cmp++; if (r_cycle !== 8) begin n_bad++; $display("FAIL rstall_rsp_cycle: got %0d exp 8", r_cycle); end
    n_cmp++; if ({r_pulses, r_data} !== {32'd1, 32'h12345678}) begin n_bad++; $display("FAIL rstall_data: got n%0d %h exp n1 12345678", r_pulses, r_data); end
  endtask

  task automatic test_reset_mid;
    int seen;
    set_slave(0, 0, 0, 0, 0);
    b_never = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h55AA55AA;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bready, busy} !== 2'b11) begin n_bad++; $display("FAIL rstmid_in_wr_resp: got %b exp 11", {bready, busy}); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({cmd_ready, busy, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err} !== 9'h0) begin
      n_bad++; $display("FAIL rstmid_async_outs: got %b exp 0", {cmd_ready, busy, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}); end
    n_cmp++; if ({awaddr, wdata} !== 64'h0) begin n_bad++; $display("FAIL rstmid_async_data: got %h exp 0", {awaddr, wdata}); end
    seen = 0;
    @(negedge clk); if (rsp_valid) seen++;
    b_never = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready_after: got %b exp 1", cmd_ready); end
    for (int k = 0; k < 4; k++) begin if (rsp_valid) seen++; @(negedge clk); end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_rsp: got %0d exp 0", seen); end
    run_cmd(1'b0, 32'h10, 32'h0, 20);
    n_cmp++; if ({r_cycle, r_data} !== {32'd3, 32'hDEADBEEF}) begin n_bad++; $display("FAIL rstmid_recover: got c%0d %h exp c3 deadbeef", r_cycle, r_data); end
  endtask

  task automatic test_timeout;
    set_slave(0, 0, 0, 0, 0);
    b_never = 1'b1;
`ifdef AXI4_MASTER_TIMEOUT_EN
    run_cmd(1'b1, 32'h28, 32'h01020304, 30);
    n_cmp++; if (r_cycle !== 8) begin n_bad++; $display("FAIL tmo_rsp_cycle: got %0d exp 8", r_cycle); end
    n_cmp++; if ({r_err, r_data} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL tmo_rsp: got err=%b data=%h exp err=1 data=0", r_err, r_data); end
    n_cmp++; if ({h_br[7], h_br[8], h_crdy[9]} !== 3'b101) begin n_bad++; $display("FAIL tmo_bready_drop: got %b exp 101", {h_br[7], h_br[8], h_crdy[9]}); end
    b_never = 1'b0;
    run_cmd(1'b0, 32'h10, 32'h0, 20);
    n_cmp++; if ({r_cycle, r_err, r_data} !== {32'd3, 1'b0, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL tmo_recover: got c%0d e%b %h exp c3 e0 deadbeef", r_cycle, r_err, r_data); end
`else
    run_cmd(1'b1, 32'h28, 32'h01020304, 40);
    n_cmp++; if (r_cycle !== -1) begin n_bad++; $display("FAIL notmo_no_rsp: got %0d exp -1", r_cycle); end
    n_cmp++; if ({h_busy[40], h_br[40], h_crdy[40], rsp_err} !== 4'b1100) begin
      n_bad++; $display("FAIL notmo_stuck: got %b exp 1100", {h_busy[40], h_br[40], h_crdy[40], rsp_err}); end
    b_never = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({cmd_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL notmo_recover: got %b exp 10", {cmd_ready, busy}); end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write_zero_wait();
    test_read_back_to_back();
    test_write_stalls();
    test_read_stall();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/axi4_master.md
# axi4_master

Single-outstanding AXI4 master that converts a simple command/response interface into AXI write (AW/W/B) and read (AR/R) transactions. It sits directly upstream of the team's memory-backed `axi4_slave` and drives its channels. It uses the same reduced channel set: no ID, LEN, STRB or RESP. One transaction is in flight at a time.

## Interface
Parameters:
- ADDR_W, 32, address width of cmd_addr, awaddr and araddr
- DATA_W, 32, data width of cmd_wdata, wdata, rdata and rsp_rdata
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with AXI4_MASTER_TIMEOUT_EN

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transaction address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  timeout abort flag; valid with rsp_valid
- busy  out  1  high in every state except IDLE
- awaddr  out  ADDR_W; awvalid out 1; awready in 1
- wdata  out  DATA_W; wvalid out 1; wready in 1
- bvalid  in  1; bready  out  1
- araddr  out  ADDR_W; arvalid out 1; arready in 1
- rdata  in  DATA_W; rvalid in 1; rready  out  1

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On a command handshake, capture addr and wdata, then go to WR_REQ if cmd_write=1, else RD_REQ.
- WR_REQ:
  - awvalid and wvalid are both asserted on state entry.
  - Each valid drops independently on the edge where its ready is sampled high. Both handshakes may occur in the same cycle or in either order.
  - Go to WR_RESP once both AW and W are done.
  - awaddr and wdata hold stable while their valid is high.
- WR_RESP:
  - bready=1.
  - On bvalid&&bready, go to DONE with rsp_rdata=0.
- RD_REQ:
  - arvalid=1 until arready is sampled high, then go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid&&rready, capture rdata into rsp_rdata and go to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle, cmd_ready=0, then IDLE.
- Responses are never back-pressured.
- A valid is never withdrawn before its handshake, except on a timeout abort.
- Reset values: all outputs 0 (cmd_ready=0 during reset, 1 from the first cycle after release); state IDLE.
- Reset mid-transaction drops all valids and readies immediately; the transaction is discarded and no rsp_valid is issued.

## Timing
- cmd_ready is registered and equals (state==IDLE).
- AXI valids assert the cycle after the command handshake.
- Zero-wait write (cmd handshake at cycle 0):
  - awvalid/wvalid at cycle 1, handshakes at cycle 1;
  - bready at cycle 2, bvalid sampled at cycle 2;
  - rsp_valid at cycle 3; cmd_ready at cycle 4.
- Zero-wait read: arvalid at cycle 1; rready at cycle 2; rsp_valid at cycle 3.
- Minimum command-to-response latency is 3 cycles; back-to-back commands are spaced 4 cycles minimum.
- Slave stalls add cycles one-for-one.

## Configuration
- AXI4_MASTER_TIMEOUT_EN defined:
  - A counter clears on command acceptance and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT_CYCLES-1 without completion, all AXI valids and readies deassert on the next edge and the FSM enters DONE with rsp_err=1 and rsp_rdata=0.
  - A handshake that completes in the same cycle as the limit wins, with rsp_err=0.
- Not defined:
  - No counter; rsp_err is tied to 0; the FSM waits indefinitely for the slave.

## Structure
- axi4_pkg: state enum, default ADDR_W/DATA_W constants, and the counter width $clog2(TIMEOUT_CYCLES)+1.
- One sub-module, axi4_timeout_ctr: inputs clr and en; output expired. It is instantiated only under AXI4_MASTER_TIMEOUT_EN.

## Test plan
- Zero-wait slave, write 0xDEADBEEF to 0x10 -> awvalid/wvalid at cycle 1, rsp_valid at cycle 3, rsp_err=0; a following read of 0x10 returns rsp_rdata=0xDEADBEEF.
- wready delayed 3 cycles after awready -> awvalid drops after 1 cycle; wvalid is held 4 cycles with stable wdata; exactly one rsp_valid.
- rvalid delayed 5 cycles on a read of 0x20 -> rready held high throughout; rsp_valid appears 5 cycles later than the zero-wait case.
- reset_n pulsed low while in WR_RESP -> all outputs 0 asynchronously; no rsp_valid; cmd_ready=1 one cycle after release.
- With macro, TIMEOUT_CYCLES=8, bvalid never asserted -> rsp_valid with rsp_err=1 at the 8th cycle after acceptance; bready drops.
- Without macro, same stimulus -> FSM stays in WR_RESP and busy=1 indefinitely.
